vga_controller: RTL and testbench

- Monochrome 800x600@60 Hz VGA timing generator and renderer for the tic-tac-toe board.
- Generates HSYNC/VSYNC from a 40 MHz pixel clock.
- Draws a 3x3 grid and the per-cell symbols from a 36-bit board-state vector supplied by the game logic.
- Outputs one pixel bit per clock plus a visible-area qualifier for the downstream DAC/encoder.

---
 rtl/vga_controller.sv | 178 +++++++++++++++++
 tb/tb_vga_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_controller.sv
`timescale 1ns/1ps
// 800x600@60 VGA timing generator that renders the tic-tac-toe board from a latched copy of the
// game state. All four outputs are registered from the same counter state, so they stay aligned.
module vga_controller #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [35:0] CONTROL_ARRAY,
  output logic        PIXEL_VALUE,
  output logic        PIXEL_VALID,
  output logic        HSYNC,
  output logic        VSYNC
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
  localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0]  V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0]  VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  localparam logic [10:0] BOARD_X0  = 11'd130;
  localparam logic [10:0] BOARD_X1  = 11'd670;
  localparam logic [9:0]  BOARD_Y0  = 10'd30;
  localparam logic [9:0]  BOARD_Y1  = 10'd570;
  localparam logic [7:0]  CELL_LAST = 8'd179;

  logic [10:0] r_h;
  logic [9:0]  r_v;
  logic [35:0] r_board;

  logic [10:0] w_bx;
  logic [9:0]  w_by;
  logic [1:0]  w_col;
  logic [1:0]  w_row;
  logic [7:0]  w_lx;
  logic [7:0]  w_ly;
  logic [3:0]  w_idx;
  logic [3:0]  w_code;
  logic [3:0]  w_cells [9];

  logic        w_visible;
  logic        w_hs;
  logic        w_vs;
  logic        w_in_board;
  logic        w_grid;
  logic        w_x_box;
  logic        w_x_shape;
  logic        w_ring;
  logic        w_cursor;
  logic        w_fill;
  logic        w_pixel;

  logic [7:0]  w_adiff;
  logic [8:0]  w_sum;
  logic [8:0]  w_asum;
  logic [7:0]  w_ox;
  logic [7:0]  w_oy;
  logic [15:0] w_r2;
  logic [7:0]  w_ex;
  logic [7:0]  w_ey;
  logic [7:0]  w_edge;

  // Raster counters
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + 10'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  // Board state is captured once per frame at the start of vertical blanking, so a frame never tears
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_board <= '0;
    end else if (r_h == 11'd0 && r_v == V_VIS_W) begin
      r_board <= CONTROL_ARRAY;
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_cells
    assign w_cells[gi] = r_board[4*gi +: 4];
  end

  assign w_visible  = (r_h < H_VIS_W) && (r_v < V_VIS_W);
  assign w_hs       = (r_h >= HS_START) && (r_h <= HS_END);
  assign w_vs       = (r_v >= VS_START) && (r_v <= VS_END);
  assign w_in_board = (r_h >= BOARD_X0) && (r_h < BOARD_X1) &&
                      (r_v >= BOARD_Y0) && (r_v < BOARD_Y1);

  assign w_bx = r_h - BOARD_X0;
  assign w_by = r_v - BOARD_Y0;

  always_comb begin
    w_col = 2'd0;
    w_lx  = 8'(w_bx);
    if (w_bx >= 11'd360) begin
      w_col = 2'd2;
      w_lx  = 8'(w_bx - 11'd360);
    end else if (w_bx >= 11'd180) begin
      w_col = 2'd1;
      w_lx  = 8'(w_bx - 11'd180);
    end
  end

  always_comb begin
    w_row = 2'd0;
    w_ly  = 8'(w_by);
    if (w_by >= 10'd360) begin
      w_row = 2'd2;
      w_ly  = 8'(w_by - 10'd360);
    end else if (w_by >= 10'd180) begin
      w_row = 2'd1;
      w_ly  = 8'(w_by - 10'd180);
    end
  end

  assign w_idx  = {2'b00, w_row} * 4'd3 + {2'b00, w_col};
  assign w_code = w_cells[w_idx];

  assign w_grid = (w_lx < 8'd4) || (w_lx >= 8'd176) || (w_ly < 8'd4) || (w_ly >= 8'd176);

  // X: two diagonal bands clipped to a 140x140 box
  assign w_x_box   = (w_lx >= 8'd20) && (w_lx <= 8'd159) && (w_ly >= 8'd20) && (w_ly <= 8'd159);
  assign w_adiff   = (w_lx >= w_ly) ? (w_lx - w_ly) : (w_ly - w_lx);
  assign w_sum     = {1'b0, w_lx} + {1'b0, w_ly};
  assign w_asum    = (w_sum >= 9'd179) ? (w_sum - 9'd179) : (9'd179 - w_sum);
  assign w_x_shape = w_x_box && ((w_adiff < 8'd6) || (w_asum < 9'd6));

  assign w_ox   = (w_lx >= 8'd90) ? (w_lx - 8'd90) : (8'd90 - w_lx);
  assign w_oy   = (w_ly >= 8'd90) ? (w_ly - 8'd90) : (8'd90 - w_ly);
  assign w_r2   = {8'd0, w_ox} * {8'd0, w_ox} + {8'd0, w_oy} * {8'd0, w_oy};
  assign w_ring = (w_r2 >= 16'd2500) && (w_r2 < 16'd3844);

  assign w_ex     = (w_lx < (CELL_LAST - w_lx)) ? w_lx : (CELL_LAST - w_lx);
  assign w_ey     = (w_ly < (CELL_LAST - w_ly)) ? w_ly : (CELL_LAST - w_ly);
  assign w_edge   = (w_ex < w_ey) ? w_ex : w_ey;
  assign w_cursor = w_code[3] && (w_edge >= 8'd8) && (w_edge <= 8'd13);

  assign w_fill  = ((w_code[1:0] == 2'd1) && w_x_shape) ||
                   ((w_code[1:0] == 2'd2) && w_ring) ||
                   w_cursor;
  // Highlight inverts only the cell interior; grid lines stay solid
  assign w_pixel = w_visible && w_in_board && (w_grid || (w_fill ^ w_code[2]));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PIXEL_VALUE <= 1'b0;
      PIXEL_VALID <= 1'b0;
      HSYNC       <= 1'b0;
      VSYNC       <= 1'b0;
    end else begin
      PIXEL_VALUE <= w_pixel;
      PIXEL_VALID <= w_visible;
      HSYNC       <= w_hs;
      VSYNC       <= w_vs;
    end
  end

endmodule

// File: tb/tb_vga_controller.sv
`timescale 1ns/1ps
// Directed bench for vga_controller: pixel probes at hand-computed screen positions across two
// frames, sync/valid timing from a monitor, and async reset behaviour.
module tb_vga_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [35:0] CONTROL_ARRAY = '0;
  logic        PIXEL_VALUE;
  logic        PIXEL_VALID;
  logic        HSYNC;
  logic        VSYNC;

  vga_controller dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .CONTROL_ARRAY(CONTROL_ARRAY),
    .PIXEL_VALUE  (PIXEL_VALUE),
    .PIXEL_VALID  (PIXEL_VALID),
    .HSYNC        (HSYNC),
    .VSYNC        (VSYNC)
  );

  always #12.5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Reference raster position: the counter value the DUT holds between rising edges
  int cnt_h = 0;
  int cnt_v = 0;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_h <= 0;
      cnt_v <= 0;
    end else if (cnt_h == 1055) begin
      cnt_h <= 0;
      cnt_v <= (cnt_v == 627) ? 0 : cnt_v + 1;
    end else begin
      cnt_h <= cnt_h + 1;
    end
  end

  typedef struct {
    bit          load;
    int          x;
    int          y;
    logic        pix;
    logic [35:0] data;
    string       name;
  } vec_t;
  vec_t vecs[$];

  function automatic void addp(input int f, input int x, input int y, input logic p);
    vec_t v;
    v.load = 1'b0;
    v.x    = x;
    v.y    = y;
    v.pix  = p;
    v.data = '0;
    v.name = $sformatf("frame%0d_px_%0d_%0d", f, x, y);
    vecs.push_back(v);
  endfunction

  function automatic void addl(input int x, input int y, input logic [35:0] d);
    vec_t v;
    v.load = 1'b1;
    v.x    = x;
    v.y    = y;
    v.pix  = 1'b0;
    v.data = d;
    v.name = $sformatf("load_at_%0d_%0d", x, y);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Returns one cycle after the DUT counters sat at (x,y): outputs then show that position
  task automatic goto_pix(input int x, input int y, output bit ok);
    int n;
    n = 0;
    while (!(cnt_h == x && cnt_v == y) && n < 700000) begin
      @(negedge CLK);
      n++;
    end
    ok = (cnt_h == x && cnt_v == y);
    @(negedge CLK);
  endtask

  // Timing monitor
  bit     mon_en = 1'b0;
  longint cyc = 0;
  bit     hs_p = 1'b0;
  bit     vs_p = 1'b0;
  longint hs_last = -1;
  int     hs_w = 0;
  int     hs_periods = 0;
  int     hs_bad = 0;
  int     vs_n = 0;
  longint vs_t0 = 0;
  longint vs_t1 = 0;
  int     vs_w = 0;
  int     vs_w0 = -1;
  longint valid_cnt = 0;
  int     blank_bad = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        cyc++;
        if (HSYNC && !hs_p) begin
          if (hs_last >= 0) begin
            hs_periods++;
            if (cyc - hs_last != 1056) hs_bad++;
          end
          hs_last = cyc;
          hs_w    = 0;
        end
        if (HSYNC) hs_w++;
        if (!HSYNC && hs_p && hs_last >= 0 && hs_w != 128) hs_bad++;
        if (VSYNC && !vs_p) begin
          if (vs_n == 0) vs_t0 = cyc;
          else if (vs_n == 1) vs_t1 = cyc;
          vs_n++;
          vs_w = 0;
        end
        if (VSYNC) vs_w++;
        if (!VSYNC && vs_p && vs_n == 1) vs_w0 = vs_w;
        if (vs_n == 1 && PIXEL_VALID) valid_cnt++;
        if (PIXEL_VALUE && !PIXEL_VALID) blank_bad++;
        hs_p = HSYNC;
        vs_p = VSYNC;
      end
    end
  end

  initial begin
    #45000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit abort;
    abort = 1'b0;

    // Frame 0: empty board; new state loaded mid-frame must not show until frame 1
    addp(0, 129, 30, 1'b0);
    addp(0, 130, 30, 1'b1);
    addp(0, 100, 100, 1'b0);
    addp(0, 309, 100, 1'b1);
    addp(0, 310, 100, 1'b1);
    addp(0, 805, 100, 1'b0);
    addp(0, 220, 120, 1'b0);
    addp(0, 400, 120, 1'b0);
    addl(0, 300, 36'h1_8605_4321);
    addp(0, 400, 320, 1'b0);
    addp(0, 220, 480, 1'b0);
    addp(0, 320, 480, 1'b0);
    addp(0, 580, 480, 1'b0);
    addp(0, 669, 569, 1'b1);
    addp(0, 670, 569, 1'b0);
    // Frame 1: cells 0..8 = 1,2,3,4,5,0,6,8,1
    addp(1, 149, 49, 1'b0);
    addp(1, 150, 50, 1'b1);
    addp(1, 220, 60, 1'b0);
    addp(1, 220, 120, 1'b1);
    addp(1, 400, 120, 1'b0);
    addp(1, 449, 120, 1'b0);
    addp(1, 450, 120, 1'b1);
    addp(1, 455, 120, 1'b1);
    addp(1, 461, 120, 1'b1);
    addp(1, 462, 120, 1'b0);
    addp(1, 580, 120, 1'b0);
    addp(1, 625, 120, 1'b0);
    addp(1, 160, 180, 1'b1);
    addp(1, 400, 240, 1'b1);
    addp(1, 220, 300, 1'b1);
    addp(1, 312, 300, 1'b1);
    addp(1, 400, 300, 1'b0);
    addp(1, 580, 300, 1'b0);
    addp(1, 400, 320, 1'b1);
    addp(1, 220, 480, 1'b1);
    addp(1, 275, 480, 1'b0);
    addp(1, 317, 480, 1'b0);
    addp(1, 320, 480, 1'b1);
    addp(1, 323, 480, 1'b1);
    addp(1, 324, 480, 1'b0);
    addp(1, 580, 480, 1'b1);

    #5 RESET = 1'b0;
    #1;
    chk("reset_pixel_value", PIXEL_VALUE, 1'b0);
    chk("reset_pixel_valid", PIXEL_VALID, 1'b0);
    chk("reset_hsync", HSYNC, 1'b0);
    chk("reset_vsync", VSYNC, 1'b0);
    #100;
    @(negedge CLK);
    RESET  = 1'b1;
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      if (!abort) begin
        goto_pix(vecs[i].x, vecs[i].y, ok);
        if (!ok) begin
          chk({vecs[i].name, "_reached"}, 64'd0, 64'd1);
          abort = 1'b1;
        end else if (vecs[i].load) begin
          CONTROL_ARRAY = vecs[i].data;
          $display("load CONTROL_ARRAY=%h at (%0d,%0d)", vecs[i].data, vecs[i].x, vecs[i].y);
        end else begin
          chk(vecs[i].name, PIXEL_VALUE, vecs[i].pix);
          chk({vecs[i].name, "_valid"}, PIXEL_VALID,
              (vecs[i].x < 800 && vecs[i].y < 600) ? 1'b1 : 1'b0);
        end
      end
    end

    if (!abort) begin
      // Past frame-1 vsync: monitor results, then reset while HSYNC is high
      goto_pix(900, 612, ok);
      chk("reach_900_612", ok, 1'b1);
      mon_en = 1'b0;
      chk("hsync_period_width_errors", hs_bad, 0);
      chk("hsync_periods_seen_gt_1000", (hs_periods > 1000) ? 1 : 0, 1);
      chk("vsync_rises", vs_n, 2);
      chk("vsync_period", vs_t1 - vs_t0, 663168);
      chk("vsync_width", vs_w0, 4224);
      chk("valid_per_frame", valid_cnt, 480000);
      chk("blanking_errors", blank_bad, 0);
      chk("pre_reset_hsync", HSYNC, 1'b1);
      chk("pre_reset_vsync", VSYNC, 1'b0);

      RESET = 1'b0;
      #1;
      chk("midframe_reset_hsync", HSYNC, 1'b0);
      chk("midframe_reset_valid", PIXEL_VALID, 1'b0);
      chk("midframe_reset_value", PIXEL_VALUE, 1'b0);
      #100;
      @(negedge CLK);
      RESET = 1'b1;

      goto_pix(839, 0, ok);
      chk("restart_hsync_839", HSYNC, 1'b0);
      goto_pix(840, 0, ok);
      chk("restart_hsync_840", HSYNC, 1'b1);
      goto_pix(130, 30, ok);
      chk("restart_px_130_30", PIXEL_VALUE, 1'b1);
      goto_pix(220, 120, ok);
      chk("restart_board_cleared_220_120", PIXEL_VALUE, 1'b0);
      chk("restart_reached", ok, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
